// File: rtl/serial_adder8.sv
// Bit-serial ripple-carry adder: one full-adder slice and a carry flop, LSB first, start/busy/done handshake.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag (ovf).
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one operand bit added per clock
// DONE   | one-cycle completion pulse; start here chains the next operation
module serial_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [WIDTH-1:0] r_ps;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic w_accept;
  logic w_last;
  logic w_s;
  logic w_c;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_s      = r_xs[0] ^ r_ys[0] ^ r_carry;
  assign w_c      = (r_xs[0] & r_ys[0]) | (r_xs[0] & r_carry) | (r_ys[0] & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Result registers only move on the edge that consumes the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs    <= '0;
      r_ys    <= '0;
      r_ps    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_xs    <= x;
      r_ys    <= y;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_xs    <= {1'b0, r_xs[WIDTH-1:1]};
      r_ys    <= {1'b0, r_ys[WIDTH-1:1]};
      r_ps    <= {w_s, r_ps[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= {w_s, r_ps[WIDTH-1:1]};
        cout <= w_c;
`ifdef SERIAL_ADD_OVF_EN
        ovf  <= r_carry ^ w_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder8.sv
// Self-checking bench for serial_adder8: directed and random operations against an arithmetic reference.
module tb_serial_adder8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
  logic       prev_ovf = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_sum = '0;
  logic       prev_cout = 1'b0;

  serial_adder8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic c, input bit keep);
    int unsigned tot;
    int          k;
    int          busy_n;
    bit          seen;
`ifdef SERIAL_ADD_OVF_EN
    int          sv;
    logic        eo;
    sv = int'($signed(a)) + int'($signed(b)) + int'(c);
    eo = (sv > 127) || (sv < -128);
`endif
    tot = 32'(a) + 32'(b) + 32'(c);
    x = a;
    y = b;
    cin = c;
    start = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    start = keep;
    busy_n = 0;
    seen = 1'b0;
    k = 1;
    while (!seen && k <= 20) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        chk("sum_hold_in_run", 32'(sum), 32'(prev_sum));
        x = 8'($urandom);
        y = 8'($urandom);
        cin = 1'($urandom);
        @(negedge clk);
        k++;
      end
    end
    chk("done_latency", 32'(k), 32'd9);
    chk("busy_cycles", 32'(busy_n), 32'd8);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), tot & 32'hFF);
    chk("cout", 32'(cout), (tot >> 8) & 32'h1);
    prev_sum = tot[7:0];
    prev_cout = tot[8];
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", 32'(ovf), 32'(eo));
    prev_ovf = eo;
`endif
    if (!keep) begin
      start = 1'b0;
      @(negedge clk);
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    op(8'd100, 8'd27, 1'b0, 1'b0);
    op(8'd255, 8'd1, 1'b0, 1'b0);
    op(8'd0, 8'd0, 1'b1, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    op(8'd127, 8'd1, 1'b0, 1'b0);
    op(8'd128, 8'd128, 1'b0, 1'b0);
`endif
    op(8'd5, 8'd3, 1'b0, 1'b1);
    op(8'd9, 8'd4, 1'b1, 1'b1);
    op(8'd200, 8'd100, 1'b0, 1'b0);
    op(8'd100, 8'd27, 1'b0, 1'b0);

    // Abort mid-operation: result registers must clear and no done may follow.
    x = 8'd50;
    y = 8'd60;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("abort_ovf", 32'(ovf), 32'd0);
    prev_ovf = 1'b0;
`endif
    prev_sum = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    op(8'd1, 8'd2, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      op(8'($urandom), 8'($urandom), 1'($urandom), (i < 19) ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
